// File: rtl/rf_pkg.sv
// Shared types, limits and helpers for the rf_1r1w_le_gen register file and its init sequencer.
package rf_pkg;

  localparam int unsigned RF_MIN_DEPTH = 2;
  localparam int unsigned RF_MAX_DEPTH = 64;

  typedef logic [0:0] rf_seq_state_t;
  localparam rf_seq_state_t IDLE  = 1'b0;
  localparam rf_seq_state_t SWEEP = 1'b1;

  // Address width for a given entry count, never narrower than one bit.
  function automatic int unsigned rf_addr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rf_1r1w_le_gen_if.sv
// Read/write access port of rf_1r1w_le_gen; master drives requests, slave returns read data.
interface rf_1r1w_le_gen_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_mask,
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  wr_mask,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/rf_init_seq.sv
// Init sweep sequencer: walks every entry once per init_req and flags the entry being reloaded.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = rf_addr_width(DEPTH)
) (
  input  logic             wr_clk,
  input  logic             reset,
  input  logic             init_req,
  output logic             init_busy,
  output logic [DEPTH-1:0] sweep_load_o
);

  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  rf_seq_state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        // init_req is ignored here; the sweep always runs to completion
        if (ptr_q == LastPtr) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign init_busy = (state_q == SWEEP);

  always_comb begin
    sweep_load_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      sweep_load_o[k] = init_busy && (ptr_q == AW'(k));
    end
  end

endmodule

// File: rtl/rf_1r1w_le_gen.sv
// Parametrised 1R1W register file with per-bit load-from-init, masked writes and an init sweep.
// Define RF_1R1W_BYPASS_EN to forward same-address write results to the read port.
module rf_1r1w_le_gen
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = rf_addr_width(DEPTH)
) (
  input  logic                wr_clk,
  input  logic                reset,
  rf_1r1w_le_gen_if.slave     bus,
  input  logic [DEPTH*DW-1:0] rf_init,
  input  logic [DEPTH*DW-1:0] rf_laen,
  input  logic                init_req,
  output logic                init_busy,
  output logic                wr_drop,
  output logic                addr_err,
  output logic [DEPTH*DW-1:0] rf_data
);

  if (DEPTH < RF_MIN_DEPTH || DEPTH > RF_MAX_DEPTH) begin : g_depth_check
    $error("rf_1r1w_le_gen: DEPTH outside supported range");
  end

  localparam logic [AW:0] DepthLim = (AW + 1)'(DEPTH);

  logic [DEPTH*DW-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]    sweep_load;
  logic                wr_in_range, rd_in_range, wr_ok;
  logic                wr_drop_d, addr_err_d;
  logic [DW-1:0]       rd_sel;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                rd_valid_q, wr_drop_q, addr_err_q;

  rf_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .wr_clk       (wr_clk),
    .reset        (reset),
    .init_req     (init_req),
    .init_busy    (init_busy),
    .sweep_load_o (sweep_load)
  );

  assign wr_in_range = ({1'b0, bus.wr_addr} < DepthLim);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DepthLim);
  assign wr_ok       = bus.wr_en && wr_in_range && !init_busy;

  // Per-bit priority: sweep load over load-enable over masked write over hold.
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    logic [DW-1:0] init_k, laen_k, wmask_k, cur_k;

    assign init_k  = rf_init[k*DW +: DW];
    assign laen_k  = rf_laen[k*DW +: DW];
    assign cur_k   = mem_q[k*DW +: DW];
    assign wmask_k = (wr_ok && (bus.wr_addr == AW'(k))) ? bus.wr_mask : '0;

    assign mem_d[k*DW +: DW] = sweep_load[k] ? init_k :
                               ((laen_k & init_k) |
                                (~laen_k & wmask_k & bus.wr_data) |
                                (~laen_k & ~wmask_k & cur_k));
  end

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      mem_q <= rf_init;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rf_data = mem_q;

  // Out-of-range read addresses match no entry and so return zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.rd_addr == AW'(k)) begin
`ifdef RF_1R1W_BYPASS_EN
        rd_sel = (bus.wr_en && (bus.wr_addr == bus.rd_addr)) ? mem_d[k*DW +: DW] :
                                                               mem_q[k*DW +: DW];
`else
        rd_sel = mem_q[k*DW +: DW];
`endif
      end
    end
  end

  assign rd_data_d  = bus.rd_en ? rd_sel : rd_data_q;
  assign wr_drop_d  = bus.wr_en && (init_busy || !wr_in_range);
  assign addr_err_d = (bus.wr_en && !wr_in_range) || (bus.rd_en && !rd_in_range);

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
      wr_drop_q  <= wr_drop_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign wr_drop      = wr_drop_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_rf_1r1w_le_gen.sv
// Bench for rf_1r1w_le_gen: DEPTH=8 and DEPTH=6 instances share stimulus and are checked
// every cycle against a behavioural model, plus hand-computed spot values.
module tb_rf_1r1w_le_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en, rd_en, init_req;
  logic [2:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data, wr_mask;
  logic [63:0] rf_init, rf_laen;
  logic        busy8, drop8, err8, busy6, drop6, err6;
  logic [63:0] data8;
  logic [47:0] data6;

  rf_1r1w_le_gen_if #(.AW(3), .DW(8)) bus8 ();
  rf_1r1w_le_gen_if #(.AW(3), .DW(8)) bus6 ();

  assign bus8.wr_en   = wr_en;
  assign bus8.wr_addr = wr_addr;
  assign bus8.wr_data = wr_data;
  assign bus8.wr_mask = wr_mask;
  assign bus8.rd_en   = rd_en;
  assign bus8.rd_addr = rd_addr;
  assign bus6.wr_en   = wr_en;
  assign bus6.wr_addr = wr_addr;
  assign bus6.wr_data = wr_data;
  assign bus6.wr_mask = wr_mask;
  assign bus6.rd_en   = rd_en;
  assign bus6.rd_addr = rd_addr;

  rf_1r1w_le_gen #(.DEPTH(8), .DW(8)) dut8 (
    .wr_clk    (clk),
    .reset     (rst_n),
    .bus       (bus8),
    .rf_init   (rf_init),
    .rf_laen   (rf_laen),
    .init_req  (init_req),
    .init_busy (busy8),
    .wr_drop   (drop8),
    .addr_err  (err8),
    .rf_data   (data8)
  );

  rf_1r1w_le_gen #(.DEPTH(6), .DW(8)) dut6 (
    .wr_clk    (clk),
    .reset     (rst_n),
    .bus       (bus6),
    .rf_init   (rf_init[47:0]),
    .rf_laen   (rf_laen[47:0]),
    .init_req  (init_req),
    .init_busy (busy6),
    .wr_drop   (drop6),
    .addr_err  (err6),
    .rf_data   (data6)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = DEPTH 8, index 1 = DEPTH 6.
  int          dep [2] = '{8, 6};
  logic [7:0]  m [2][8];
  logic        m_busy [2];
  int          m_ptr [2];
  logic [7:0]  m_rd [2];
  logic        m_val [2], m_drop [2], m_err [2];

  task automatic model_edge(input int i);
    int         d;
    bit         w_in, r_in, w_ok;
    logic [7:0] nxt [8];
    logic [7:0] rd_v;
    d    = dep[i];
    w_in = (int'(wr_addr) < d);
    r_in = (int'(rd_addr) < d);
    w_ok = wr_en && w_in && !m_busy[i];
    for (int k = 0; k < 8; k++) nxt[k] = m[i][k];
    for (int k = 0; k < d; k++) begin
      if (m_busy[i] && m_ptr[i] == k) begin
        nxt[k] = rf_init[k*8 +: 8];
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (rf_laen[k*8 + b]) nxt[k][b] = rf_init[k*8 + b];
          else if (w_ok && int'(wr_addr) == k && wr_mask[b]) nxt[k][b] = wr_data[b];
        end
      end
    end
    rd_v = 8'h00;
    if (r_in) rd_v = m[i][rd_addr];
`ifdef RF_1R1W_BYPASS_EN
    if (r_in && wr_en && wr_addr == rd_addr) rd_v = nxt[rd_addr];
`endif
    if (rd_en) m_rd[i] = rd_v;
    m_val[i]  = rd_en;
    m_drop[i] = wr_en && (m_busy[i] || !w_in);
    m_err[i]  = (wr_en && !w_in) || (rd_en && !r_in);
    for (int k = 0; k < 8; k++) m[i][k] = nxt[k];
    if (m_busy[i]) begin
      if (m_ptr[i] == d - 1) begin
        m_busy[i] = 1'b0;
        m_ptr[i]  = 0;
      end else begin
        m_ptr[i]++;
      end
    end else if (init_req) begin
      m_busy[i] = 1'b1;
      m_ptr[i]  = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) m[i][k] = rf_init[k*8 +: 8];
        m_busy[i] = 1'b0;
        m_ptr[i]  = 0;
        m_rd[i]   = 8'h00;
        m_val[i]  = 1'b0;
        m_drop[i] = 1'b0;
        m_err[i]  = 1'b0;
      end else begin
        model_edge(i);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rd_data8", bus8.rd_data, m_rd[0]);
    chk("rd_valid8", bus8.rd_valid, m_val[0]);
    chk("busy8", busy8, m_busy[0]);
    chk("drop8", drop8, m_drop[0]);
    chk("err8", err8, m_err[0]);
    for (int k = 0; k < 8; k++) chk($sformatf("rf8[%0d]", k), data8[k*8 +: 8], m[0][k]);
    chk("rd_data6", bus6.rd_data, m_rd[1]);
    chk("rd_valid6", bus6.rd_valid, m_val[1]);
    chk("busy6", busy6, m_busy[1]);
    chk("drop6", drop6, m_drop[1]);
    chk("err6", err6, m_err[1]);
    for (int k = 0; k < 6; k++) chk($sformatf("rf6[%0d]", k), data6[k*8 +: 8], m[1][k]);
  end

  task automatic idle();
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    init_req = 1'b0;
    wr_addr  = '0;
    rd_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    rf_laen  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] mk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = mk;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
  endtask

  int n8, n6;

  initial begin
    idle();
    rf_init = {8'h78, 8'h67, 8'h56, 8'h45, 8'hA5, 8'h23, 8'h12, 8'h01};
    tick();
    tick();
    chk("lit_rst_e3", data8[31:24], 8'hA5);
    chk("lit_rst_rd", bus8.rd_data, 8'h00);
    chk("lit_rst_val", bus8.rd_valid, 1'b0);
    rst_n = 1'b1;

    rd(3'd3);
    tick();
    idle();
    chk("lit_rd3", bus8.rd_data, 8'hA5);
    chk("lit_rd3_val", bus8.rd_valid, 1'b1);
    tick();
    chk("lit_rd3_hold", bus8.rd_data, 8'hA5);
    chk("lit_val_low", bus8.rd_valid, 1'b0);

    wr(3'd2, 8'h30, 8'hFF);
    tick();
    idle();
    wr(3'd2, 8'hFF, 8'h0F);
    tick();
    idle();
    chk("lit_mask_e2", data8[23:16], 8'h3F);

    wr(3'd5, 8'hFF, 8'hFF);
    rf_laen[47:40] = 8'h01;
    tick();
    idle();
    chk("lit_laen_e5_8", data8[47:40], 8'hFE);
    chk("lit_laen_e5_6", data6[47:40], 8'hFE);

    wr(3'd1, 8'h11, 8'hFF);
    tick();
    idle();
    wr(3'd1, 8'h22, 8'hFF);
    rd(3'd1);
    tick();
    idle();
`ifdef RF_1R1W_BYPASS_EN
    chk("lit_rw_same", bus8.rd_data, 8'h22);
`else
    chk("lit_rw_same", bus8.rd_data, 8'h11);
`endif
    chk("lit_rw_e1", data8[15:8], 8'h22);

    for (int k = 0; k < 7; k++) begin
      wr(3'(k), 8'hC0 | 8'(k), 8'hFF);
      tick();
      idle();
    end
    wr(3'd7, 8'hC7, 8'hFF);
    rd(3'd6);
    tick();
    idle();
    chk("lit_oor_err6", err6, 1'b1);
    chk("lit_oor_drop6", drop6, 1'b1);
    chk("lit_oor_rd6", bus6.rd_data, 8'h00);
    chk("lit_oor_val6", bus6.rd_valid, 1'b1);
    chk("lit_oor_drop8", drop8, 1'b0);
    chk("lit_oor_rd8", bus8.rd_data, 8'hC6);

    init_req = 1'b1;
    tick();
    idle();
    n8 = 0;
    n6 = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy8) n8++;
      if (busy6) n6++;
      if (c == 2) wr(3'd4, 8'h99, 8'hFF);
      tick();
      idle();
      if (c == 2) begin
        chk("lit_busy_drop8", drop8, 1'b1);
        chk("lit_busy_e4", data8[39:32], 8'hC4);
      end
    end
    chk("lit_busy_len8", n8, 8);
    chk("lit_busy_len6", n6, 6);
    chk("lit_sweep_all8", data8, rf_init);
    chk("lit_sweep_all6", data6, rf_init[47:0]);

    wr(3'd7, 8'hEE, 8'hFF);
    tick();
    idle();
    chk("lit_e7_ee", data8[63:56], 8'hEE);
    init_req = 1'b1;
    tick();
    idle();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_abort_busy8", busy8, 1'b0);
    chk("lit_abort_busy6", busy6, 1'b0);
    chk("lit_abort_e7", data8[63:56], 8'h78);
    tick();
    rst_n = 1'b1;
    tick();

    wr(3'd0, 8'h55, 8'hFF);
    rf_laen[7:0] = 8'hFF;
    tick();
    chk("lit_laen_hold1", data8[7:0], 8'h01);
    tick();
    chk("lit_laen_hold2", data8[7:0], 8'h01);
    idle();
    wr(3'd0, 8'h55, 8'hF0);
    tick();
    idle();
    chk("lit_mask_e0", data8[7:0], 8'h51);
    wr(3'd0, 8'hFE, 8'hFF);
    rf_laen[7:0] = 8'h0F;
    tick();
    idle();
    chk("lit_laen_part", data8[7:0], 8'hF1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_1r1w_le_gen.md
# rf_1r1w_le_gen

Parametrised single-read/single-write register file with per-bit load-from-init, masked writes, a registered read port and a sequential init sweep. It is the generic successor of the fixed 8x8 latch-enable register file and sits between configuration logic (which supplies init values and load enables) and the datapath that reads entries by address. All state updates are synchronous to `wr_clk`; only `reset` is asynchronous.

## Interface
- `DEPTH`, 8, number of entries (2..64; need not be a power of two).
- `DW`, 8, entry width in bits.
- `AW`, `$clog2(DEPTH)` (minimum 1), address width.

- `wr_clk`  in  1  write/read clock.
- `reset`  in  1  reset, asynchronous, active-low; clock is `wr_clk`.
- `wr_en`  in  1  write request.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DW  write data.
- `wr_mask`  in  DW  per-bit write mask; 1 means the bit is written.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DW  registered read data.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` updated.
- `rf_init`  in  DEPTH*DW  flat init values; entry k occupies `[k*DW +: DW]`.
- `rf_laen`  in  DEPTH*DW  flat per-bit load enables, same layout.
- `init_req`  in  1  start a full init sweep.
- `init_busy`  out  1  sweep in progress.
- `wr_drop`  out  1  one-cycle pulse: write discarded (busy or out of range).
- `addr_err`  out  1  one-cycle pulse: `rd_addr` or `wr_addr` ≥ DEPTH on an enabled access.
- `rf_data`  out  DEPTH*DW  flat view of all entries.

## Operation
- Reset (`reset`=0): every entry = its `rf_init` slice. `rd_data`=0, `rd_valid`=0, `init_busy`=0, `wr_drop`=0, `addr_err`=0, FSM=IDLE, sweep pointer=0.
- Per-entry, per-bit update priority on each clock edge:
  1. Sweep loads this entry: whole entry = init.
  2. `rf_laen` bit set: bit = init bit.
  3. Write hits the entry with mask bit set: bit = `wr_data` bit.
  4. Otherwise the bit holds.
- Writes are discarded with `wr_drop`=1 next cycle when `init_busy`=1 or `wr_addr` ≥ DEPTH. The out-of-range case also raises `addr_err`.
- FSM states:
  - IDLE: `init_req`=1 → SWEEP with pointer=0.
  - SWEEP: loads entry[pointer] each cycle and increments the pointer. On loading DEPTH-1 it returns to IDLE with pointer=0.
  - `init_req` during SWEEP is ignored. `init_busy`=1 exactly while in SWEEP.
- Reads are allowed in any state. `rd_addr` ≥ DEPTH returns 0 with `rd_valid`=1 and `addr_err`=1.
- Without `rd_en`, `rd_data` holds its last value.

## Timing
- Read latency 1: `rd_en` at edge N gives `rd_data`/`rd_valid` after edge N+1. `rd_valid` is low otherwise.
- Write, `rf_laen` and sweep loads are visible on `rf_data` one cycle after the sampling edge.
- A sweep takes exactly DEPTH cycles. `init_busy` rises the cycle after `init_req` and falls after the DEPTH-th load.
- `rf_laen` held high keeps reloading every cycle; it is level-sensitive and sampled only on clock edges.
- Simultaneous read and write to the same address: the read returns the pre-edge entry value (see Configuration).
- Reset asserted mid-sweep aborts the sweep immediately: IDLE, all entries = init.

## Configuration
- `RF_1R1W_BYPASS_EN` defined: same-cycle read/write to the same in-range address returns the post-update value. That value includes mask, `rf_laen` and sweep priority merging, i.e. it equals `rf_data` for that entry one cycle later.
- `RF_1R1W_BYPASS_EN` undefined: the read returns the old value. No bypass mux is built.

## Structure
- Shared package `rf_pkg`:
  - FSM state typedef `rf_seq_state_t` {IDLE, SWEEP}.
  - Address-width helper function.
  - Limits `RF_MIN_DEPTH`=2 and `RF_MAX_DEPTH`=64.
- One sub-module, `rf_init_seq`: FSM, sweep pointer and `init_busy`; outputs a one-hot per-entry sweep-load vector.
- The storage array, read register and bypass stay in the top level.

## Test plan
- Reset with `rf_init` entry3=8'hA5 → `rf_data` entry3=8'hA5, `rd_data`=0, `rd_valid`=0. Then read addr3 → 8'hA5 one cycle later with `rd_valid` pulse.
- Write addr2 data 8'hFF, mask 8'h0F over entry 8'h30 → entry2=8'h3F.
- Same cycle: write addr5 data 8'hFF with `rf_laen` entry5=8'h01 and init bit0=0 → entry5=8'hFE.
- `init_req` with DEPTH=8 after overwriting all entries → `init_busy` high for 8 cycles, entries restored in order 0..7. A write during busy → `wr_drop` pulse, entry unchanged.
- DEPTH=6: write addr7 and read addr6 → `addr_err` pulses, `wr_drop` pulses, `rd_data`=0.
- Read and write addr1 in the same cycle (old 8'h11, new 8'h22) → `rd_data`=8'h22 with bypass, 8'h11 without.
